// File: rtl/alu_pkg.sv
// Shared opcodes and default geometry for the lane-parallel vector ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 20;
  localparam int ALU_LANES = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MOV = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100
  } alu_op_e;

endpackage

// File: rtl/alu_lane.sv
// One combinational ALU lane: unsigned add/sub/mov/mul/div.
module alu_lane
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  logic             b_zero;
  logic [WIDTH-1:0] quo;

  assign b_zero = (b == '0);
  // Divide-by-zero yields all ones instead of an undefined quotient
  assign quo = b_zero ? '1 : a / b;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MOV:  y = a;
      OP_MUL:  y = a * b;
      OP_DIV:  y = quo;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_main.sv
// Lane-parallel vector ALU with a single registered result vector.
module alu_main
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int LANES = ALU_LANES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0][WIDTH-1:0]  A,
  input  logic [LANES-1:0][WIDTH-1:0]  B,
  input  logic [2:0]                   Operation,
  output logic [LANES-1:0][WIDTH-1:0]  Result
);

  logic [LANES-1:0][WIDTH-1:0] res_d;
  logic [LANES-1:0][WIDTH-1:0] res_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .a  (A[i]),
      .b  (B[i]),
      .op (Operation),
      .y  (res_d[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) res_q <= '0;
    else        res_q <= res_d;
  end

  assign Result = res_q;

endmodule

// File: tb/tb_alu_main.sv
// Directed table-driven bench for alu_main plus reset/latency sequences.
module tb_alu_main;

  typedef logic [7:0][19:0] lv_t;

  typedef struct {
    string      name;
    lv_t        a;
    lv_t        b;
    logic [2:0] op;
    lv_t        exp;
  } vec_t;

  localparam int NV = 13;
  localparam int M = 1048575;

  logic       clk;
  logic       reset;
  lv_t        A;
  lv_t        B;
  logic [2:0] Operation;
  lv_t        Result;

  int pass_cnt;
  int total_cnt;
  vec_t tv [NV];

  alu_main #(
    .WIDTH(20),
    .LANES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .Result    (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic lv_t v8(
    input int x7, input int x6,
    input int x5, input int x4,
    input int x3, input int x2,
    input int x1, input int x0
  );
    return {20'(x7), 20'(x6), 20'(x5), 20'(x4),
            20'(x3), 20'(x2), 20'(x1), 20'(x0)};
  endfunction

  task automatic check(input string nm, input lv_t exp);
    total_cnt++;
    if (Result === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, Result, exp);
  endtask

  task automatic drive(input lv_t a, input lv_t b,
                       input logic [2:0] op);
    A = a;
    B = b;
    Operation = op;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    tv[0] = '{"add",
      v8(100,254,251,200,5,10,100,15),
      v8(100,1,1,45,25,1,2,10), 3'b000,
      v8(200,255,252,245,30,11,102,25)};
    tv[1] = '{"add_wrap",
      v8(M,M,M,M,M,M,M,M),
      v8(1,1,1,1,1,1,1,1), 3'b000,
      v8(0,0,0,0,0,0,0,0)};
    tv[2] = '{"sub",
      v8(100,255,251,200,25,10,100,15),
      v8(100,55,1,45,5,1,2,10), 3'b001,
      v8(0,200,250,155,20,9,98,5)};
    tv[3] = '{"sub_wrap",
      v8(0,0,0,0,0,0,0,0),
      v8(1,1,1,1,1,1,1,1), 3'b001,
      v8(M,M,M,M,M,M,M,M)};
    tv[4] = '{"mov",
      v8(100,255,251,200,25,10,100,15),
      v8(9,9,9,9,9,9,9,9), 3'b010,
      v8(100,255,251,200,25,10,100,15)};
    tv[5] = '{"mul",
      v8(2,6,10,15,4,8,25,50),
      v8(2,2,20,2,5,5,2,2), 3'b011,
      v8(4,12,200,30,20,40,50,100)};
    tv[6] = '{"mul_trunc",
      v8(1024,1024,1025,1024,1024,1024,1024,3),
      v8(1024,1024,1024,1024,1024,1024,1024,5),
      3'b011,
      v8(0,0,1024,0,0,0,0,15)};
    tv[7] = '{"div",
      v8(2,6,10,15,200,8,25,50),
      v8(2,2,2,2,100,4,5,2), 3'b100,
      v8(1,3,5,7,2,2,5,25)};
    tv[8] = '{"div_zero",
      v8(7,9,0,100,M,5,3,20),
      v8(0,2,0,7,3,0,4,20), 3'b100,
      v8(M,4,M,14,349525,M,0,1)};
    tv[9] = '{"rsv101",
      v8(1,2,3,4,5,6,7,8),
      v8(8,7,6,5,4,3,2,1), 3'b101,
      v8(0,0,0,0,0,0,0,0)};
    tv[10] = '{"add2",
      v8(1,2,3,4,5,6,7,8),
      v8(8,7,6,5,4,3,2,1), 3'b000,
      v8(9,9,9,9,9,9,9,9)};
    tv[11] = '{"rsv110",
      v8(1,2,3,4,5,6,7,8),
      v8(8,7,6,5,4,3,2,1), 3'b110,
      v8(0,0,0,0,0,0,0,0)};
    tv[12] = '{"rsv111",
      v8(M,2,3,4,5,6,7,8),
      v8(1,7,6,5,4,3,2,1), 3'b111,
      v8(0,0,0,0,0,0,0,0)};

    drive(tv[0].a, tv[0].b, 3'b000);
    reset = 1'b1;
    #1 reset = 1'b0;
    #1 check("reset_no_clk", '0);
    @(posedge clk);
    #1 check("reset_hold", '0);
    @(negedge clk);
    reset = 1'b1;

    // back-to-back: new opcode every cycle
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].op);
      if (i > 0) begin
        #1 check({tv[i].name, "_pre"}, tv[i-1].exp);
      end
      @(posedge clk);
      #1 check(tv[i].name, tv[i].exp);
      @(negedge clk);
    end

    // async clear mid-stream, between edges
    drive(tv[5].a, tv[5].b, tv[5].op);
    @(posedge clk);
    #1 check("pre_rst", tv[5].exp);
    #2 reset = 1'b0;
    #1 check("mid_rst", '0);
    @(posedge clk);
    #1 check("rst_edge", '0);
    @(negedge clk);
    reset = 1'b1;
    drive(tv[2].a, tv[2].b, tv[2].op);
    #1 check("rel_pre", '0);
    @(posedge clk);
    #1 check("rel_first", tv[2].exp);
    @(negedge clk);
    drive(tv[7].a, tv[7].b, tv[7].op);
    #1 check("rel_hold", tv[2].exp);
    @(posedge clk);
    #1 check("rel_second", tv[7].exp);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_main.md
# alu_main

Lane-parallel unsigned vector ALU for the vector processor's execute stage. Applies one operation, selected by a 3-bit opcode, to all lanes of operand vectors A and B at once. Registers the per-lane results into Result, so results appear one clock after operands and opcode are presented.

## Interface
- WIDTH, default 20: bits per lane element.
- LANES, default 8: number of lanes.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  [LANES-1:0][WIDTH-1:0]  operand vector A, packed; lane i is A[i].
- B  input  [LANES-1:0][WIDTH-1:0]  operand vector B, packed.
- Operation  input  3  opcode, applied uniformly to every lane.
- Result  output  [LANES-1:0][WIDTH-1:0]  registered result vector.

## Operation
- Per lane i, all values unsigned WIDTH-bit:
  - 3'b000 ADD: (A[i]+B[i]) mod 2^WIDTH; carry discarded.
  - 3'b001 SUB: (A[i]-B[i]) mod 2^WIDTH; borrow wraps.
  - 3'b010 MOV: A[i]; B ignored.
  - 3'b011 MUL: low WIDTH bits of A[i]*B[i]; upper bits discarded.
  - 3'b100 DIV: floor(A[i]/B[i]), truncating quotient; remainder discarded.
    - B[i]==0: lane result is all ones (2^WIDTH-1).
  - 3'b101–3'b111: reserved; lane result is 0.
- Lanes are fully independent; no cross-lane carry, no flags, no saturation.
- Unknown or X inputs need no special handling.

## Timing
- Combinational datapath from A, B and Operation to the Result register D-input.
- Result captures at every rising clk edge while reset is high. No enable and no handshake.
- Latency is 1 cycle.
  - Inputs stable before edge N produce Result valid after edge N.
  - Result holds until edge N+1.
- Opcode and operands may change every cycle. Each edge captures the values present at that edge.
- reset low: Result goes to all zeros immediately, without waiting for clk. It stays zero while reset is low.
- Reset released mid-stream: the first capture is at the first rising edge with reset high.
- The combinational path, including the WIDTH-bit divider, must close in one clock period at WIDTH=20. Pipelining is out of scope.

## Structure
- Shared package alu_pkg holds:
  - the opcode enum: OP_ADD=3'b000, OP_SUB=3'b001, OP_MOV=3'b010, OP_MUL=3'b011, OP_DIV=3'b100;
  - default WIDTH/LANES constants.
- Sub-module alu_lane:
  - parameterised WIDTH;
  - purely combinational;
  - inputs a, b, op; output y, implementing the per-lane operation table.
- alu_main holds a generate loop of LANES alu_lane instances plus the single async-reset result register.

## Test plan
- ADD: A={100,254,251,200,5,10,100,15}, B={100,1,1,45,25,1,2,10}, op 000 -> next cycle Result={200,255,252,245,30,11,102,25}. Also A=2^20-1, B=1 -> 0 (wrap).
- SUB: A={100,255,251,200,25,10,100,15}, B={100,55,1,45,5,1,2,10}, op 001 -> Result={0,200,250,155,20,9,98,5}. Also A=0, B=1 -> 2^20-1.
- MOV/MUL:
  - op 010, A={100,255,251,200,25,10,100,15} -> Result=A.
  - op 011, A={2,6,10,15,4,8,25,50}, B={2,2,20,2,5,5,2,2} -> {4,12,200,30,20,40,50,100}.
  - A=B=2^10 -> 0 (truncation).
- DIV: A={2,6,10,15,200,8,25,50}, B={2,2,2,2,100,4,5,2}, op 100 -> {1,3,5,7,2,2,5,25}. Also B[i]=0 -> lane = 2^20-1; reserved op 101 -> all zeros.
- Reset/latency:
  - Result is 0 while reset is low, with no clk edge required.
  - Reset asserted mid-stream clears Result asynchronously.
  - After release, Result updates exactly one edge after inputs change.
  - Back-to-back opcode changes every cycle yield correct per-cycle results.
